// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter between ALU and LSU writeback ports feeding one register-file write port,
// plus a pending-write scoreboard used for source-operand hazard checks.
module regfile_wb_arbiter (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        alu_valid_i,
    output logic        alu_ready_o,
    input  logic [4:0]  alu_rd_i,
    input  logic [31:0] alu_data_i,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [4:0]  lsu_rd_i,
    input  logic [31:0] lsu_data_i,
    input  logic        issue_i,
    input  logic [4:0]  issue_rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    output logic        rs1_busy_o,
    output logic        rs2_busy_o,
    output logic [31:0] busy_o,
    output logic        write_o,
    output logic [4:0]  write_reg_o,
    output logic [31:0] write_data_o
);

    // Which source wins the next tie; it flips to the other source after every transfer.
    typedef enum logic {
        PRIO_ALU,
        PRIO_LSU
    } prio_e;

    prio_e       prio_q, prio_d;
    logic        alu_grant, lsu_grant, xfer;
    logic [4:0]  xfer_rd;
    logic [31:0] xfer_data;
    logic [31:0] set_mask, clr_mask, busy_q, busy_d;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            prio_q <= PRIO_ALU;
        end else begin
            prio_q <= prio_d;
        end
    end

    always_comb begin
        prio_d    = prio_q;
        alu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (alu_valid_i && lsu_valid_i) begin
            alu_grant = (prio_q == PRIO_ALU);
            lsu_grant = (prio_q == PRIO_LSU);
        end else begin
            alu_grant = alu_valid_i;
            lsu_grant = lsu_valid_i;
        end
        if (alu_grant) begin
            prio_d = PRIO_LSU;
        end else if (lsu_grant) begin
            prio_d = PRIO_ALU;
        end
    end

    assign alu_ready_o = alu_grant;
    assign lsu_ready_o = lsu_grant;
    assign xfer        = alu_grant | lsu_grant;
    assign xfer_rd     = alu_grant ? alu_rd_i   : lsu_rd_i;
    assign xfer_data   = alu_grant ? alu_data_i : lsu_data_i;

    // x0 writes are accepted but swallowed here so the register file never sees them.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            write_o      <= 1'b0;
            write_reg_o  <= 5'd0;
            write_data_o <= 32'd0;
        end else begin
            write_o <= xfer && (xfer_rd != 5'd0);
            if (xfer) begin
                write_reg_o  <= xfer_rd;
                write_data_o <= xfer_data;
            end
        end
    end

    // Set is OR-ed in after the clear so a same-edge issue to the retiring register wins.
    always_comb begin
        set_mask = 32'd0;
        clr_mask = 32'd0;
        if (issue_i) begin
            set_mask = 32'd1 << issue_rd_i;
        end
        if (write_o) begin
            clr_mask = 32'd1 << write_reg_o;
        end
        busy_d = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign rs1_busy_o = busy_q[rs1_i];
    assign rs2_busy_o = busy_q[rs2_i];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table for grants, queue scoreboard for
// the registered write port, and a small model of the busy scoreboard.
module tb_regfile_wb_arbiter;

    logic        clk_i, reset_ni;
    logic        alu_valid_i, alu_ready_o, lsu_valid_i, lsu_ready_o;
    logic [4:0]  alu_rd_i, lsu_rd_i, issue_rd_i, rs1_i, rs2_i, write_reg_o;
    logic [31:0] alu_data_i, lsu_data_i, busy_o, write_data_o;
    logic        issue_i, rs1_busy_o, rs2_busy_o, write_o;

    regfile_wb_arbiter dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
        .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
        .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
        .issue_i(issue_i), .issue_rd_i(issue_rd_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i),
        .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
        .busy_o(busy_o), .write_o(write_o),
        .write_reg_o(write_reg_o), .write_data_o(write_data_o)
    );

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic        iss;
        logic [4:0]  ird;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        exp_ar;
        logic        exp_lr;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    int          total = 0;
    int          bad   = 0;
    wr_t         exp_q[$];
    wr_t         cur_wr;
    logic [31:0] busy_model;
    vec_t        tbl[11];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                                input logic iss, input logic [4:0] ird,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic exp_ar, input logic exp_lr);
        vec_t v;
        v.av = av; v.ard = ard; v.adata = adata;
        v.lv = lv; v.lrd = lrd; v.ldata = ldata;
        v.iss = iss; v.ird = ird; v.rs1 = rs1; v.rs2 = rs2;
        v.exp_ar = exp_ar; v.exp_lr = exp_lr;
        return v;
    endfunction

    task automatic driveIdle();
        alu_valid_i = 1'b0; alu_rd_i = 5'd0; alu_data_i = 32'd0;
        lsu_valid_i = 1'b0; lsu_rd_i = 5'd0; lsu_data_i = 32'd0;
        issue_i = 1'b0; issue_rd_i = 5'd0; rs1_i = 5'd0; rs2_i = 5'd0;
    endtask

    // Drive on the falling edge, check the combinational grants, queue the expected write.
    task automatic applyStimulus(input vec_t v);
        wr_t e;
        @(negedge clk_i);
        alu_valid_i = v.av; alu_rd_i = v.ard; alu_data_i = v.adata;
        lsu_valid_i = v.lv; lsu_rd_i = v.lrd; lsu_data_i = v.ldata;
        issue_i = v.iss; issue_rd_i = v.ird; rs1_i = v.rs1; rs2_i = v.rs2;
        #1;
        check("alu_ready", {31'd0, alu_ready_o}, {31'd0, v.exp_ar});
        check("lsu_ready", {31'd0, lsu_ready_o}, {31'd0, v.exp_lr});
        e.we = 1'b0; e.rd = 5'd0; e.data = 32'd0;
        if (v.exp_ar) begin
            e.we = (v.ard != 5'd0); e.rd = v.ard; e.data = v.adata;
        end else if (v.exp_lr) begin
            e.we = (v.lrd != 5'd0); e.rd = v.lrd; e.data = v.ldata;
        end
        exp_q.push_back(e);
    endtask

    // Advance the busy model at the edge, then compare the registered outputs just after it.
    task automatic checkOutput(input vec_t v);
        @(posedge clk_i);
        if (cur_wr.we) busy_model[cur_wr.rd] = 1'b0;
        if (v.iss && v.ird != 5'd0) busy_model[v.ird] = 1'b1;
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            cur_wr.we = 1'b0;
        end else begin
            cur_wr = exp_q.pop_front();
        end
        check("write_o", {31'd0, write_o}, {31'd0, cur_wr.we});
        if (cur_wr.we) begin
            check("write_reg", {27'd0, write_reg_o}, {27'd0, cur_wr.rd});
            check("write_data", write_data_o, cur_wr.data);
        end
        check("busy", busy_o, busy_model);
        check("rs1_busy", {31'd0, rs1_busy_o}, {31'd0, busy_model[v.rs1]});
        check("rs2_busy", {31'd0, rs2_busy_o}, {31'd0, busy_model[v.rs2]});
    endtask

    task automatic step(input vec_t v);
        applyStimulus(v);
        checkOutput(v);
    endtask

    initial begin
        // Table starts with ALU-only grant so its tie outcomes do not depend on prior history.
        tbl[0]  = mk(0, 0, 0,            0, 0, 0,            1, 5, 5, 0, 0, 0);
        tbl[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,            0, 0, 5, 1, 1, 0);
        tbl[2]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 5, 0, 0, 0);
        tbl[3]  = mk(1, 1, 32'h11,       1, 2, 32'h22,       1, 7, 7, 2, 0, 1);
        tbl[4]  = mk(1, 3, 32'h33,       1, 4, 32'h44,       0, 0, 7, 4, 1, 0);
        tbl[5]  = mk(0, 0, 0,            1, 0, 32'h12345678, 0, 0, 7, 0, 0, 1);
        tbl[6]  = mk(1, 7, 32'h77,       0, 0, 0,            0, 0, 7, 3, 1, 0);
        tbl[7]  = mk(0, 0, 0,            0, 0, 0,            1, 7, 7, 5, 0, 0);
        tbl[8]  = mk(0, 0, 0,            0, 0, 0,            1, 0, 7, 0, 0, 0);
        tbl[9]  = mk(1, 7, 32'h99,       0, 0, 0,            0, 0, 7, 0, 1, 0);
        tbl[10] = mk(0, 0, 0,            0, 0, 0,            0, 0, 7, 0, 0, 0);

        driveIdle();
        reset_ni   = 1'b0;
        busy_model = 32'd0;
        cur_wr.we = 1'b0; cur_wr.rd = 5'd0; cur_wr.data = 32'd0;
        #2;
        check("rst_write_o", {31'd0, write_o}, 32'd0);
        check("rst_write_reg", {27'd0, write_reg_o}, 32'd0);
        check("rst_write_data", write_data_o, 32'd0);
        check("rst_busy", busy_o, 32'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #2 reset_ni = 1'b1;

        // Continuous ties right after reset: ALU first, then alternating, no bubbles.
        for (int i = 0; i < 4; i++) begin
            step(mk(1, 5'(10 + i), 32'hA000 + i, 1, 5'(20 + i), 32'hB000 + i,
                    0, 0, 0, 0, (i % 2 == 0), (i % 2 == 1)));
        end
        for (int i = 0; i < 3; i++) begin
            step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        step(mk(1, 6, 32'hC6, 1, 8, 32'hC8, 0, 0, 0, 0, 1, 0));

        for (int i = 0; i < 11; i++) begin
            step(tbl[i]);
        end

        // Reset landing between the accepting edge and the write cycle drops the write.
        step(mk(1, 9, 32'hA5A5A5A5, 0, 0, 0, 1, 9, 9, 0, 1, 0));
        driveIdle();
        #1 reset_ni = 1'b0;
        #1;
        check("midrst_write_o", {31'd0, write_o}, 32'd0);
        check("midrst_write_reg", {27'd0, write_reg_o}, 32'd0);
        check("midrst_write_data", write_data_o, 32'd0);
        check("midrst_busy", busy_o, 32'd0);
        #1 reset_ni = 1'b1;
        exp_q.delete();
        busy_model = 32'd0;
        cur_wr.we = 1'b0; cur_wr.rd = 5'd0; cur_wr.data = 32'd0;
        step(mk(1, 9, 32'h1234, 1, 11, 32'h5678, 0, 0, 9, 11, 1, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
